// File: rtl/cpu_mc_core.sv
// cpu_mc_core: multi-cycle CPU core with a 16-bit instruction format,
// four DATA_W-bit registers, Z/C flags, a req/ack data-memory port that
// tolerates wait states, a run gate sampled in FETCH, and an absorbing HALT.
module cpu_mc_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LED_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [LED_W-1:0]  led_out,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQZ = 4'hA,
    OP_JMP  = 4'hB,
    OP_HALT = 4'hF
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] regs_q [4];
  logic              z_q, c_q;
  logic [DATA_W-1:0] res_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [LED_W-1:0]  led_q;

  op_e               op;
  logic [1:0]        rd, rs;
  logic [DATA_W-1:0] rd_val, rs_val, imm_z, imm_s;
  logic [ADDR_W-1:0] ea, target, pc_inc;
  logic [DATA_W:0]   alu_w;
  logic              c_upd;

  assign op     = op_e'(ir_q[15:12]);
  assign rd     = ir_q[11:10];
  assign rs     = ir_q[9:8];
  assign rd_val = regs_q[rd];
  assign rs_val = regs_q[rs];
  assign imm_z  = DATA_W'(ir_q[7:0]);
  assign imm_s  = DATA_W'(signed'(ir_q[7:0]));
  assign ea     = ADDR_W'(rs_val + imm_s);
  assign target = ADDR_W'(ir_q[7:0]);
  assign pc_inc = pc_q + ADDR_W'(1);

  // ALU: the extra top bit of alu_w carries carry-out / borrow
  always_comb begin
    alu_w = '0;
    c_upd = 1'b0;
    case (op)
      OP_LDI:  alu_w = {1'b0, imm_z};
      OP_ADD:  begin alu_w = {1'b0, rd_val} + {1'b0, rs_val}; c_upd = 1'b1; end
      OP_SUB:  begin alu_w = {1'b0, rd_val} - {1'b0, rs_val}; c_upd = 1'b1; end
      OP_AND:  alu_w = {1'b0, rd_val & rs_val};
      OP_OR:   alu_w = {1'b0, rd_val | rs_val};
      OP_XOR:  alu_w = {1'b0, rd_val ^ rs_val};
      OP_ADDI: begin alu_w = {1'b0, rd_val} + {1'b0, imm_s}; c_upd = 1'b1; end
      default: ;
    endcase
  end

  // Next-state and next-PC selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH:  if (run) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        pc_d = pc_inc;
        case (op)
          OP_LDI, OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_XOR, OP_ADDI:          state_d = S_WB;
          OP_LD, OP_ST:                    state_d = S_MEM;
          OP_BEQZ: begin
            if (rd_val == '0) pc_d = target;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = target;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default:                         state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_ack) state_d = we_q ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // FSM state and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Datapath: IR latch, result/flag capture, memory bus, register write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= '0;
      regs_q  <= '{default: '0};
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      res_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      led_q   <= '0;
    end else begin
      case (state_q)
        S_DECODE: ir_q <= imem_data;
        S_EXEC: begin
          res_q <= alu_w[DATA_W-1:0];
          if (c_upd) c_q <= alu_w[DATA_W];
          if (op == OP_LD || op == OP_ST) begin
            addr_q  <= ea;
            wdata_q <= rd_val;
            we_q    <= (op == OP_ST);
          end
        end
        S_MEM: if (dmem_ack && !we_q) res_q <= dmem_rdata;
        S_WB: begin
          regs_q[rd] <= res_q;
          z_q        <= (res_q == '0);
          led_q      <= LED_W'(res_q);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc_dbg     = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign led_out    = led_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed self-checking bench for cpu_mc_core with a synchronous ROM model
// and a data memory whose ack latency is programmable.
module tb_cpu_mc_core;

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        dmem_ack;
  logic [3:0]  led_out;
  logic        halted;
  logic [7:0]  pc_dbg;

  logic [15:0] rom [256];
  logic [7:0]  dm  [256];
  int unsigned req_cyc = 0;
  int unsigned wait_n  = 0;
  logic        stray_ack;

  int total    = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  cpu_mc_core #(.DATA_W(8), .ADDR_W(8), .LED_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .led_out    (led_out),
    .halted     (halted),
    .pc_dbg     (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction ROM
  always @(posedge clk) imem_data <= rom[imem_addr];

  // data memory: ack after wait_n extra cycles of req, or forced by stray_ack
  always @(posedge clk) begin
    if (dmem_req && dmem_ack && dmem_we) dm[dmem_addr] <= dmem_wdata;
    if (!dmem_req || dmem_ack) req_cyc <= 0;
    else                       req_cyc <= req_cyc + 1;
  end
  assign dmem_ack   = stray_ack | (dmem_req && (req_cyc == wait_n));
  assign dmem_rdata = dm[dmem_addr];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b1;
    stray_ack = 1'b0;
    wait_n    = 3;

    // ---- program 1: arithmetic, store with wait states, load back, HALT
    clear_rom();
    rom[0] = 16'h1405;  // LDI r1,05
    rom[1] = 16'h1803;  // LDI r2,03
    rom[2] = 16'h2600;  // ADD r1,r2
    rom[3] = 16'h9602;  // ST  r1,[r2+2]
    rom[4] = 16'h1000;  // LDI r0,00
    rom[5] = 16'h8E02;  // LD  r3,[r2+2]
    rom[6] = 16'hF000;  // HALT
    reset = 1'b1;
    tick(2);
    chk("rst_pc",     pc_dbg,     8'h00);
    chk("rst_imem",   imem_addr,  8'h00);
    chk("rst_led",    led_out,    4'h0);
    chk("rst_halted", halted,     1'b0);
    chk("rst_req",    dmem_req,   1'b0);
    chk("rst_we",     dmem_we,    1'b0);
    chk("rst_addr",   dmem_addr,  8'h00);
    chk("rst_wdata",  dmem_wdata, 8'h00);
    chk("rst_z",      dut.z_q,    1'b0);
    chk("rst_c",      dut.c_q,    1'b0);
    reset = 1'b0;
    tick(11);
    chk("ldi_led_11", led_out, 4'h3);
    tick(1);
    chk("add_led_12", led_out, 4'h8);
    tick(3);
    chk("st_req0",   dmem_req,   1'b1);
    chk("st_we",     dmem_we,    1'b1);
    chk("st_addr0",  dmem_addr,  8'h05);
    chk("st_wdata0", dmem_wdata, 8'h08);
    chk("st_pc",     pc_dbg,     8'h04);
    tick(3);
    chk("st_req3",   dmem_req,   1'b1);
    chk("st_addr3",  dmem_addr,  8'h05);
    chk("st_wdata3", dmem_wdata, 8'h08);
    tick(1);
    chk("st_req_drop", dmem_req, 1'b0);
    chk("st_mem",      dm[5],    8'h08);
    wait_n = 0;
    tick(4);
    chk("ldi0_led", led_out, 4'h0);
    tick(3);
    chk("ld_req", dmem_req, 1'b1);
    chk("ld_we",  dmem_we,  1'b0);
    tick(1);
    chk("ld_req_drop", dmem_req, 1'b0);
    tick(1);
    chk("ld_led", led_out, 4'h8);
    tick(3);
    chk("p1_halted", halted, 1'b1);
    chk("p1_pc",     pc_dbg, 8'h06);
    stray_ack = 1'b1;
    tick(3);
    chk("stray_req",    dmem_req, 1'b0);
    chk("stray_led",    led_out,  4'h8);
    chk("stray_halted", halted,   1'b1);
    stray_ack = 1'b0;

    // ---- program 2: flags and wrap-around arithmetic
    clear_rom();
    rom[0] = 16'h10FF;  // LDI  r0,FF
    rom[1] = 16'h7001;  // ADDI r0,01  -> 00, Z=1 C=1
    rom[2] = 16'h1401;  // LDI  r1,01
    rom[3] = 16'h7800;  // ADDI r2,00  -> 00, Z=1 C=0
    rom[4] = 16'h3100;  // SUB  r0,r1  -> FF, C=1
    rom[5] = 16'h4100;  // AND  r0,r1  -> 01, C unchanged
    rom[6] = 16'hF000;
    do_reset();
    tick(4);
    chk("ldiff_led", led_out, 4'hF);
    tick(4);
    chk("addi_led", led_out, 4'h0);
    chk("addi_z",   dut.z_q, 1'b1);
    chk("addi_c",   dut.c_q, 1'b1);
    tick(4);
    chk("ldi1_z", dut.z_q, 1'b0);
    tick(4);
    chk("addi0_z", dut.z_q, 1'b1);
    chk("addi0_c", dut.c_q, 1'b0);
    tick(4);
    chk("sub_led", led_out, 4'hF);
    chk("sub_c",   dut.c_q, 1'b1);
    chk("sub_z",   dut.z_q, 1'b0);
    tick(4);
    chk("and_led", led_out, 4'h1);
    chk("and_c",   dut.c_q, 1'b1);

    // ---- program 3: branches and PC wrap
    clear_rom();
    rom[8'h00] = 16'h1401;  // LDI  r1,01
    rom[8'h01] = 16'hA410;  // BEQZ r1,10 (not taken)
    rom[8'h02] = 16'hA020;  // BEQZ r0,20 (taken)
    rom[8'h20] = 16'hB0FF;  // JMP  FF
    rom[8'hFF] = 16'h180A;  // LDI  r2,0A
    do_reset();
    tick(7);
    chk("beqz_nt_pc", pc_dbg, 8'h02);
    tick(3);
    chk("beqz_t_pc",   pc_dbg,    8'h20);
    chk("beqz_t_imem", imem_addr, 8'h20);
    tick(3);
    chk("jmp_pc", pc_dbg, 8'hFF);
    tick(3);
    chk("wrap_pc", pc_dbg, 8'h00);
    tick(1);
    chk("wrap_led", led_out, 4'hA);

    // ---- program 4: run gate, then HALT freeze
    clear_rom();
    rom[0] = 16'h1407;  // LDI r1,07
    rom[1] = 16'hF000;  // HALT
    run = 1'b0;
    do_reset();
    tick(10);
    chk("run0_pc",   pc_dbg,    8'h00);
    chk("run0_imem", imem_addr, 8'h00);
    chk("run0_led",  led_out,   4'h0);
    run = 1'b1;
    tick(2);
    run = 1'b0;
    tick(1);
    chk("runexec_pc", pc_dbg, 8'h01);
    tick(1);
    chk("runexec_led", led_out, 4'h7);
    tick(6);
    chk("hold_pc",     pc_dbg, 8'h01);
    chk("hold_halted", halted, 1'b0);
    run = 1'b1;
    tick(3);
    chk("halt_asserted", halted, 1'b1);
    tick(20);
    chk("halt_pc20",     pc_dbg, 8'h01);
    chk("halt_halted20", halted, 1'b1);

    // ---- program 5: reset during a stalled store, with coincident ack
    clear_rom();
    rom[0] = 16'h1433;  // LDI r1,33
    rom[1] = 16'h9500;  // ST  r1,[r1+0]
    wait_n = 100;
    do_reset();
    tick(9);
    chk("mem_req",   dmem_req,   1'b1);
    chk("mem_addr",  dmem_addr,  8'h33);
    chk("mem_wdata", dmem_wdata, 8'h33);
    reset     = 1'b1;
    stray_ack = 1'b1;
    tick(1);
    chk("mrst_req",    dmem_req,   1'b0);
    chk("mrst_we",     dmem_we,    1'b0);
    chk("mrst_addr",   dmem_addr,  8'h00);
    chk("mrst_wdata",  dmem_wdata, 8'h00);
    chk("mrst_led",    led_out,    4'h0);
    chk("mrst_halted", halted,     1'b0);
    chk("mrst_pc",     pc_dbg,     8'h00);
    reset = 1'b0;
    run   = 1'b0;
    tick(3);
    chk("post_ack_req", dmem_req, 1'b0);
    chk("post_ack_pc",  pc_dbg,   8'h00);
    chk("post_ack_led", led_out,  4'h0);
    stray_ack = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
